// File: rtl/neuron_pkg.sv
// Shared types, default widths and the saturating-add helper used by the
// neuron summation scheduler.
package neuron_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int ACC_W_DEF     = 24;
    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_TERMS_DEF = 33;

    // Width of the internal add used by sat_add; wide enough for any ACC_W we use.
    localparam int SAT_CALC_W    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACCUM = 2'd2,
        HOLD  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic                         ovf;
        logic signed [SAT_CALC_W-1:0] val;
    } sat_res_t;

    // Add two sign-extended operands and clamp the result to an acc_w-bit
    // signed range, flagging when the clamp was applied.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_CALC_W-1:0] a,
        input logic signed [SAT_CALC_W-1:0] b,
        input int unsigned                  acc_w
    );
        logic signed [SAT_CALC_W-1:0] sum;
        logic signed [SAT_CALC_W-1:0] max_v;
        logic signed [SAT_CALC_W-1:0] min_v;
        sat_res_t                     res;
        sum   = a + b;
        max_v = (64'sd1 <<< (acc_w - 32'd1)) - 64'sd1;
        min_v = -(64'sd1 <<< (acc_w - 32'd1));
        if (sum > max_v) begin
            res.ovf = 1'b1;
            res.val = max_v;
        end else if (sum < min_v) begin
            res.ovf = 1'b1;
            res.val = min_v;
        end else begin
            res.ovf = 1'b0;
            res.val = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request found
// searching upward from the slot after ptr_i, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_any_o
);

    // Rotating priority scan; the pointer slot itself has lowest priority.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        found     = 1'b0;
        cand      = '0;
        gnt_idx_o = '0;
        gnt_oh_o  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                gnt_idx_o = cand;
            end else begin
                found     = found;
            end
        end
        if (found) begin
            gnt_oh_o[gnt_idx_o] = 1'b1;
        end else begin
            gnt_oh_o = '0;
        end
        gnt_any_o = found;
    end

endmodule

// File: rtl/summer_scheduler.sv
// Shares one saturating signed accumulator between NUM_REQ neuron input
// stages. One requester at a time is granted round-robin, its operand beats
// are summed up to end-of-packet (or MAX_TERMS), and the tagged result is
// held until the activation stage accepts it.
module summer_scheduler
    import neuron_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]               req_last,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             sum_valid,
    input  logic                             sum_ready,
    output logic signed [ACC_W-1:0]          sum_data,
    output logic [ID_W-1:0]                  sum_id,
    output logic [CNT_W-1:0]                 sum_count,
    output logic                             sum_sat,
    output logic                             sum_trunc
);

    sched_state_e             state_q, state_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [ID_W-1:0]          grant_q, grant_d;
    logic [NUM_REQ-1:0]       grant_oh_q, grant_oh_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     sat_q, sat_d;
    logic                     trunc_q, trunc_d;
    logic [NUM_REQ-1:0]       ready_q, ready_d;
    logic                     sum_valid_q, sum_valid_d;

    logic [NUM_REQ-1:0]       arb_oh_s;
    logic [ID_W-1:0]          arb_idx_s;
    logic                     arb_any_s;

    logic                     beat_s;
    logic                     last_s;
    logic [DATA_W-1:0]        data_s;
    logic [CNT_W-1:0]         cnt_inc_s;
    logic                     at_max_s;
    sat_res_t                 sat_res_s;
    logic                     unused_sat_hi_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (arb_oh_s),
        .gnt_idx_o (arb_idx_s),
        .gnt_any_o (arb_any_s)
    );

    // Only the granted lane can see ready, so any valid&ready bit is the accepted beat.
    assign beat_s    = |(req_valid & ready_q);
    assign last_s    = req_last[grant_q];
    assign data_s    = req_data[grant_q];
    assign cnt_inc_s = count_q + CNT_W'(1);
    assign at_max_s  = (cnt_inc_s == CNT_W'(MAX_TERMS));
    assign sat_res_s = sat_add({{(SAT_CALC_W-ACC_W){acc_q[ACC_W-1]}}, acc_q},
                               {{(SAT_CALC_W-DATA_W){data_s[DATA_W-1]}}, data_s},
                               ACC_W);
    // The clamped value always fits ACC_W; the upper bits are sign copies.
    assign unused_sat_hi_s = ^sat_res_s.val[SAT_CALC_W-1:ACC_W];

    // FSM state register; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: arbitrate only in IDLE, close a packet on last or MAX_TERMS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arb_any_s) begin
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                state_d = ACCUM;
            end
            ACCUM: begin
                if (beat_s && (last_s || at_max_s)) begin
                    state_d = HOLD;
                end else begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (sum_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM output/datapath next-values: grant capture, accumulate, pointer update.
    always_comb begin
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        acc_d      = acc_q;
        count_d    = count_q;
        sat_d      = sat_q;
        trunc_d    = trunc_q;
        case (state_q)
            IDLE: begin
                if (arb_any_s) begin
                    grant_d    = arb_idx_s;
                    grant_oh_d = arb_oh_s;
                end else begin
                    grant_d    = grant_q;
                    grant_oh_d = grant_oh_q;
                end
            end
            GRANT: begin
                acc_d   = '0;
                count_d = '0;
                sat_d   = 1'b0;
                trunc_d = 1'b0;
            end
            ACCUM: begin
                if (beat_s) begin
                    acc_d   = sat_res_s.val[ACC_W-1:0];
                    count_d = cnt_inc_s;
                    sat_d   = sat_q | sat_res_s.ovf;
                    trunc_d = at_max_s & ~last_s;
                end else begin
                    acc_d   = acc_q;
                    count_d = count_q;
                end
            end
            HOLD: begin
                if (sum_ready) begin
                    ptr_d = grant_q;
                end else begin
                    ptr_d = ptr_q;
                end
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    // Handshake outputs are registered from the state being entered.
    always_comb begin
        if (state_d == ACCUM) begin
            ready_d = grant_oh_d;
        end else begin
            ready_d = '0;
        end
        sum_valid_d = (state_d == HOLD);
    end

    // Datapath and output registers; pointer resets so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            grant_q     <= '0;
            grant_oh_q  <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            trunc_q     <= 1'b0;
            ready_q     <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            grant_oh_q  <= grant_oh_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            trunc_q     <= trunc_d;
            ready_q     <= ready_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign req_ready = ready_q;
    assign sum_valid = sum_valid_q;
    assign sum_data  = acc_q;
    assign sum_id    = grant_q;
    assign sum_count = count_q;
    assign sum_sat   = sat_q;
    assign sum_trunc = trunc_q;

endmodule

// File: tb/tb_summer_scheduler.sv
// Directed bench for summer_scheduler: a default instance (MAX_TERMS=33) and a
// long-packet instance (MAX_TERMS=512) for saturation.
module tb_summer_scheduler;

    logic clk = 1'b0;
    logic rst_n;

    // Instance A: default parameters
    logic [3:0]        va, la, rdy_a;
    logic [3:0][15:0]  da;
    logic              sra, sv_a, ssat_a, str_a;
    logic [23:0]       sd_a;
    logic [1:0]        sid_a;
    logic [5:0]        sc_a;

    // Instance B: MAX_TERMS = 512
    logic [3:0]        vb, lb, rdy_b;
    logic [3:0][15:0]  db;
    logic              srb, sv_b, ssat_b, str_b;
    logic [23:0]       sd_b;
    logic [1:0]        sid_b;
    logic [9:0]        sc_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    summer_scheduler dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (va),
        .req_data  (da),
        .req_last  (la),
        .req_ready (rdy_a),
        .sum_valid (sv_a),
        .sum_ready (sra),
        .sum_data  (sd_a),
        .sum_id    (sid_a),
        .sum_count (sc_a),
        .sum_sat   (ssat_a),
        .sum_trunc (str_a)
    );

    summer_scheduler #(.MAX_TERMS(512)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (vb),
        .req_data  (db),
        .req_last  (lb),
        .req_ready (rdy_b),
        .sum_valid (sv_b),
        .sum_ready (srb),
        .sum_data  (sd_b),
        .sum_id    (sid_b),
        .sum_count (sc_b),
        .sum_sat   (ssat_b),
        .sum_trunc (str_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Stream n beats of val from requester r of instance sel; returns #1 after
    // the edge that accepted the final beat.
    task automatic send_pkt(input int sel, input int r, input int n,
                            input logic [15:0] val, input bit last_final);
        int   beat;
        int   guard;
        logic rdy;
        beat  = 0;
        guard = 0;
        while (beat < n && guard < 4000) begin
            if (sel == 0) begin
                va[r] = 1'b1;
                da[r] = val;
                la[r] = last_final && (beat == n - 1);
            end else begin
                vb[r] = 1'b1;
                db[r] = val;
                lb[r] = last_final && (beat == n - 1);
            end
            @(negedge clk);
            rdy = (sel == 0) ? rdy_a[r] : rdy_b[r];
            if (rdy) beat++;
            @(posedge clk); #1;
            guard++;
        end
        if (sel == 0) begin
            va[r] = 1'b0;
            la[r] = 1'b0;
        end else begin
            vb[r] = 1'b0;
            lb[r] = 1'b0;
        end
        if (beat != n) chk("send_timeout", 64'(beat), 64'(n));
    endtask

    task automatic handshake_a();
        sra = 1'b1;
        @(posedge clk); #1;
        sra = 1'b0;
    endtask

    task automatic handshake_b();
        srb = 1'b1;
        @(posedge clk); #1;
        srb = 1'b0;
    endtask

    initial begin
        int exp_ids[5];
        int bcnt[4];
        int k;
        int multi;
        int guard;

        exp_ids = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        va = '0; la = '0; da = '0; sra = 1'b0;
        vb = '0; lb = '0; db = '0; srb = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_ready", 64'(rdy_a), 64'h0);
        chk("rst_bus", {sv_a, sid_a, sc_a, ssat_a, str_a, sd_a}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Request-to-ready latency, then 33 beats of +1 closed by last
        va[0] = 1'b1; da[0] = 16'd1; la[0] = 1'b0;
        @(posedge clk); #1;
        chk("lat_grant_cycle", 64'(rdy_a), 64'h0);
        @(posedge clk); #1;
        chk("lat_first_ready", 64'(rdy_a), 64'h1);
        send_pkt(0, 0, 33, 16'd1, 1'b1);
        chk("p33_valid", 64'(sv_a), 64'h1);
        chk("p33_data", 64'(sd_a), 64'd33);
        chk("p33_count", 64'(sc_a), 64'd33);
        chk("p33_id", 64'(sid_a), 64'd0);
        chk("p33_flags", {ssat_a, str_a}, 64'h0);
        chk("p33_ready_off", 64'(rdy_a), 64'h0);

        // Back-pressure: result stable, no new grant while held
        va[1] = 1'b1; da[1] = 16'hFFFE; la[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_bus", {sv_a, sid_a, sc_a, ssat_a, str_a, sd_a},
                {1'b1, 2'd0, 6'd33, 1'b0, 1'b0, 24'd33});
            chk("hold_ready", 64'(rdy_a), 64'h0);
        end
        handshake_a();
        chk("hs_drop", 64'(sv_a), 64'h0);
        @(posedge clk); #1;
        chk("regrant_gap", 64'(rdy_a), 64'h0);
        @(posedge clk); #1;
        chk("regrant_ready", 64'(rdy_a), 64'h2);

        // Single-beat negative packet from requester 1
        send_pkt(0, 1, 1, 16'hFFFE, 1'b1);
        chk("single_valid", 64'(sv_a), 64'h1);
        chk("single_data", 64'(sd_a), 64'hFFFFFE);
        chk("single_count", 64'(sc_a), 64'd1);
        chk("single_id", 64'(sid_a), 64'd1);
        handshake_a();

        // Reset mid-packet after 5 beats (requester 3 is next after 1)
        send_pkt(0, 3, 5, 16'h0010, 1'b0);
        chk("bubble_no_sum", 64'(sv_a), 64'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(rdy_a), 64'h0);
        chk("midrst_bus", {sv_a, sid_a, sc_a, ssat_a, str_a, sd_a}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        va[0] = 1'b1; da[0] = 16'd4; la[0] = 1'b0;
        va[2] = 1'b1; da[2] = 16'd9; la[2] = 1'b1;
        @(posedge clk); #1;
        chk("postrst_no_sum", 64'(sv_a), 64'h0);
        @(posedge clk); #1;
        chk("postrst_grant0", 64'(rdy_a), 64'h1);
        send_pkt(0, 0, 2, 16'd4, 1'b1);
        chk("postrst_data", 64'(sd_a), 64'd8);
        chk("postrst_id", 64'(sid_a), 64'd0);
        chk("postrst_count", 64'(sc_a), 64'd2);
        va[2] = 1'b0; la[2] = 1'b0;
        handshake_a();

        // Round robin with all four requesters valid, 2-beat packets
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sra = 1'b1;
        for (int r = 0; r < 4; r++) begin
            da[r]   = 16'(r + 1);
            bcnt[r] = 0;
        end
        la = '0;
        va = 4'hF;
        k = 0; multi = 0; guard = 0;
        while (k < 5 && guard < 500) begin
            @(negedge clk);
            if ($countones(rdy_a) > 1) multi++;
            if (sv_a) begin
                chk("rr_id", 64'(sid_a), 64'(exp_ids[k]));
                chk("rr_sum", 64'(sd_a), 64'(2 * (exp_ids[k] + 1)));
                chk("rr_count", 64'(sc_a), 64'd2);
                k++;
            end
            if (k == 5) begin
                va = '0;
                la = '0;
            end else begin
                for (int r = 0; r < 4; r++) begin
                    if (rdy_a[r] && va[r]) bcnt[r] = (bcnt[r] + 1) % 2;
                end
                @(posedge clk); #1;
                for (int r = 0; r < 4; r++) la[r] = (bcnt[r] == 1);
            end
            guard++;
        end
        chk("rr_served", 64'(k), 64'd5);
        chk("rr_onehot", 64'(multi), 64'd0);
        @(posedge clk); #1;
        sra = 1'b0;

        // Truncation at MAX_TERMS, then the next beat forms its own packet
        send_pkt(0, 0, 33, 16'd3, 1'b0);
        chk("trunc_valid", 64'(sv_a), 64'h1);
        chk("trunc_data", 64'(sd_a), 64'd99);
        chk("trunc_count", 64'(sc_a), 64'd33);
        chk("trunc_flags", {ssat_a, str_a}, 64'h1);
        handshake_a();
        send_pkt(0, 0, 1, 16'd7, 1'b1);
        chk("after_trunc_data", 64'(sd_a), 64'd7);
        chk("after_trunc_count", 64'(sc_a), 64'd1);
        chk("after_trunc_flag", 64'(str_a), 64'h0);
        handshake_a();

        // Positive saturation over 300 beats of 0x7FFF
        send_pkt(1, 0, 300, 16'h7FFF, 1'b1);
        chk("satp_valid", 64'(sv_b), 64'h1);
        chk("satp_data", 64'(sd_b), 64'h7FFFFF);
        chk("satp_flag", 64'(ssat_b), 64'h1);
        chk("satp_count", 64'(sc_b), 64'd300);
        chk("satp_trunc", 64'(str_b), 64'h0);
        handshake_b();
        // Sticky flag clears for the next packet
        send_pkt(1, 0, 1, 16'h8000, 1'b1);
        chk("satclr_data", 64'(sd_b), 64'hFF8000);
        chk("satclr_flag", 64'(ssat_b), 64'h0);
        handshake_b();
        // Negative saturation over 300 beats of 0x8000
        send_pkt(1, 0, 300, 16'h8000, 1'b1);
        chk("satn_data", 64'(sd_b), 64'h800000);
        chk("satn_flag", 64'(ssat_b), 64'h1);
        handshake_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
